mp_fifo_ptr_bypass: RTL and testbench



---
 rtl/rvh_l1d_pkg.sv | 9 +
 rtl/mp_fifo_ptr_bypass_ring_ptr_ctrl.sv | 50 +++++
 rtl/mp_fifo_ptr_bypass.sv | 130 +++++++++++++
 tb/tb_mp_fifo_ptr_bypass.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// rtl/rvh_l1d_pkg.sv - L1D shared widths used when instantiating L1D queue structures
package rvh_l1d_pkg;

    localparam int MEM_DATA_WIDTH     = 64;
    localparam int L1D_MISS_ENQ_WIDTH = 2;
    localparam int L1D_MISS_DEQ_WIDTH = 2;
    localparam int L1D_MISS_DEPTH     = 8;

endpackage

// File: rtl/mp_fifo_ptr_bypass_ring_ptr_ctrl.sv
// rtl/mp_fifo_ptr_bypass_ring_ptr_ctrl.sv - head/tail/count registers with mod-DEPTH wrap-flag arithmetic
module ring_ptr_ctrl
    import rvh_l1d_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int ENQUEUE_WIDTH = 2,
    parameter int DEQUEUE_WIDTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int EW = $clog2(ENQUEUE_WIDTH + 1),
    localparam int DW = $clog2(DEQUEUE_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [EW-1:0] n_enq,
    input  logic [DW-1:0] n_deq,
    output logic [PW:0]   head,
    output logic [PW:0]   tail,
    output logic [CW-1:0] cnt
);

    // k never exceeds DEPTH, so one conditional subtract is a full mod-DEPTH reduction
    function automatic logic [PW:0] ptr_add(input logic [PW:0] ptr, input int unsigned k);
        int unsigned sum;
        sum = 32'(ptr[PW-1:0]) + k;
        if (sum >= 32'(DEPTH)) ptr_add = {~ptr[PW], PW'(sum - 32'(DEPTH))};
        else                   ptr_add = {ptr[PW], PW'(sum)};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= ptr_add(head, 32'(n_deq));
            tail <= ptr_add(tail, 32'(n_enq));
            cnt  <= cnt + CW'(n_enq) - CW'(n_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush_i) begin
            assert (32'(cnt) + 32'(n_enq) >= 32'(n_deq));
            assert (32'(cnt) + 32'(n_enq) - 32'(n_deq) <= 32'(DEPTH));
        end
    end

endmodule

// File: rtl/mp_fifo_ptr_bypass.sv
// rtl/mp_fifo_ptr_bypass.sv - multi-port in-order ring FIFO with slot pointers and optional empty bypass
module mp_fifo_ptr_bypass
    import rvh_l1d_pkg::*;
#(
    parameter int PAYLOAD_WIDTH  = MEM_DATA_WIDTH,
    parameter int ENQUEUE_WIDTH  = L1D_MISS_ENQ_WIDTH,
    parameter int DEQUEUE_WIDTH  = L1D_MISS_DEQ_WIDTH,
    parameter int DEPTH          = L1D_MISS_DEPTH,
    parameter bit MUST_TAKEN_ALL = 1'b1,
    parameter bit BYPASS_EN      = 1'b0,
    parameter int AF_THRESH      = DEPTH - 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int EW = $clog2(ENQUEUE_WIDTH + 1),
    localparam int DW = $clog2(DEQUEUE_WIDTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic [ENQUEUE_WIDTH-1:0]               enqueue_vld_i,
    input  logic [ENQUEUE_WIDTH*PAYLOAD_WIDTH-1:0] enqueue_payload_i,
    output logic [ENQUEUE_WIDTH-1:0]               enqueue_rdy_o,
    output logic [DEQUEUE_WIDTH-1:0]               dequeue_vld_o,
    output logic [DEQUEUE_WIDTH*PAYLOAD_WIDTH-1:0] dequeue_payload_o,
    input  logic [DEQUEUE_WIDTH-1:0]               dequeue_rdy_i,
    output logic [ENQUEUE_WIDTH*(PW+1)-1:0]        enq_ptr_o,
    output logic [DEQUEUE_WIDTH*(PW+1)-1:0]        deq_ptr_o,
    output logic [CW-1:0]                          count_o,
    output logic                                   almost_full_o
);

    logic [PW:0]              head;
    logic [PW:0]              tail;
    logic [CW-1:0]            cnt;
    logic [31:0]              avail;
    logic [ENQUEUE_WIDTH-1:0] enq_fire;
    logic [DEQUEUE_WIDTH-1:0] deq_fire;
    logic [EW-1:0]            n_enq;
    logic [DW-1:0]            n_deq;
    logic [PW-1:0]            enq_idx [ENQUEUE_WIDTH];
    logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];

    function automatic logic [PW:0] ptr_add(input logic [PW:0] ptr, input int unsigned k);
        int unsigned sum;
        sum = 32'(ptr[PW-1:0]) + k;
        if (sum >= 32'(DEPTH)) ptr_add = {~ptr[PW], PW'(sum - 32'(DEPTH))};
        else                   ptr_add = {ptr[PW], PW'(sum)};
    endfunction

    ring_ptr_ctrl #(
        .DEPTH         (DEPTH),
        .ENQUEUE_WIDTH (ENQUEUE_WIDTH),
        .DEQUEUE_WIDTH (DEQUEUE_WIDTH)
    ) u_ring_ptr_ctrl (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .n_enq   (n_enq),
        .n_deq   (n_deq),
        .head    (head),
        .tail    (tail),
        .cnt     (cnt)
    );

    // Ready looks only at registered occupancy so no dequeue-side input reaches it
    assign avail = 32'(DEPTH) - 32'(cnt);

    always_comb begin
        enqueue_rdy_o = '0;
        for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
            if (MUST_TAKEN_ALL) enqueue_rdy_o[i] = (avail >= 32'(ENQUEUE_WIDTH));
            else                enqueue_rdy_o[i] = (avail > 32'(i));
        end
    end

    always_comb begin
        logic run;
        run      = 1'b1;
        enq_fire = '0;
        for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
            enq_fire[i] = run & enqueue_vld_i[i] & enqueue_rdy_o[i];
            run         = enq_fire[i];
        end
    end

    always_comb begin
        logic run;
        run      = 1'b1;
        deq_fire = '0;
        for (int i = 0; i < DEQUEUE_WIDTH; i++) begin
            deq_fire[i] = run & dequeue_vld_o[i] & dequeue_rdy_i[i];
            run         = deq_fire[i];
        end
    end

    assign n_enq = EW'($countones(enq_fire));
    assign n_deq = DW'($countones(deq_fire));

    for (genvar i = 0; i < ENQUEUE_WIDTH; i++) begin : g_enq
        logic [PW:0] ptr;
        assign ptr                           = ptr_add(tail, i);
        assign enq_ptr_o[i*(PW+1) +: (PW+1)] = ptr;
        assign enq_idx[i]                    = ptr[PW-1:0];
    end

    for (genvar i = 0; i < DEQUEUE_WIDTH; i++) begin : g_deq
        logic [PW:0] ptr;
        assign ptr                           = ptr_add(head, i);
        assign deq_ptr_o[i*(PW+1) +: (PW+1)] = ptr;
        // Bypassed lanes are still written below, so head skips them exactly as tail does
        if (BYPASS_EN && (i < ENQUEUE_WIDTH)) begin : g_byp
            assign dequeue_vld_o[i] = (cnt == '0) ? enq_fire[i] : (32'(cnt) > 32'(i));
            assign dequeue_payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] =
                (cnt == '0) ? enqueue_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] : mem[ptr[PW-1:0]];
        end else begin : g_norm
            assign dequeue_vld_o[i] = (32'(cnt) > 32'(i));
            assign dequeue_payload_o[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[ptr[PW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
            if (enq_fire[i]) mem[enq_idx[i]] <= enqueue_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        end
    end

    assign count_o       = cnt;
    assign almost_full_o = (32'(cnt) >= 32'(AF_THRESH));

endmodule

// File: tb/tb_mp_fifo_ptr_bypass.sv
// tb/tb_mp_fifo_ptr_bypass.sv - two DUT configurations against an absolute-sequence queue model
module tb_mp_fifo_ptr_bypass;

    localparam int D = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  en_vld;
    logic [1:0]  dq_rdy;
    logic [15:0] en_pay;

    logic [1:0]  erdy [2];
    logic [1:0]  dvld [2];
    logic [15:0] dpay [2];
    logic [7:0]  eptr [2];
    logic [7:0]  dptr [2];
    logic [2:0]  cnt  [2];
    logic        af   [2];

    logic [7:0]  mem_m [2][4096];
    int          hd [2];
    int          tl [2];
    bit          mta [2];
    bit          byp [2];
    logic [1:0]  ef_s [2];
    int          ne_s [2];
    int          nd_s [2];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    mp_fifo_ptr_bypass #(
        .PAYLOAD_WIDTH(8), .ENQUEUE_WIDTH(2), .DEQUEUE_WIDTH(2), .DEPTH(D),
        .MUST_TAKEN_ALL(1'b1), .BYPASS_EN(1'b0), .AF_THRESH(D - 2)
    ) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush),
        .enqueue_vld_i(en_vld), .enqueue_payload_i(en_pay), .enqueue_rdy_o(erdy[0]),
        .dequeue_vld_o(dvld[0]), .dequeue_payload_o(dpay[0]), .dequeue_rdy_i(dq_rdy),
        .enq_ptr_o(eptr[0]), .deq_ptr_o(dptr[0]), .count_o(cnt[0]), .almost_full_o(af[0])
    );

    mp_fifo_ptr_bypass #(
        .PAYLOAD_WIDTH(8), .ENQUEUE_WIDTH(2), .DEQUEUE_WIDTH(2), .DEPTH(D),
        .MUST_TAKEN_ALL(1'b0), .BYPASS_EN(1'b1), .AF_THRESH(D - 2)
    ) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush),
        .enqueue_vld_i(en_vld), .enqueue_payload_i(en_pay), .enqueue_rdy_o(erdy[1]),
        .dequeue_vld_o(dvld[1]), .dequeue_payload_o(dpay[1]), .dequeue_rdy_i(dq_rdy),
        .enq_ptr_o(eptr[1]), .deq_ptr_o(dptr[1]), .count_o(cnt[1]), .almost_full_o(af[1])
    );

    // Absolute sequence number n maps to slot n mod D with wrap flag = parity of n div D
    function automatic logic [3:0] ptrof(input int n);
        return {1'((n / D) % 2), 3'(n % D)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_check();
        int         c, av;
        logic [1:0] er, ef, ev, df;
        logic [15:0] ep;
        logic       run;
        for (int k = 0; k < 2; k++) begin
            c  = tl[k] - hd[k];
            av = D - c;
            ep = '0;
            for (int i = 0; i < 2; i++) er[i] = mta[k] ? (av >= 2) : (av > i);
            run = 1'b1;
            for (int i = 0; i < 2; i++) begin
                ef[i] = run & en_vld[i] & er[i];
                run   = ef[i];
            end
            for (int i = 0; i < 2; i++) begin
                if (byp[k] && c == 0) begin
                    ev[i]         = ef[i];
                    ep[i*8 +: 8] = en_pay[i*8 +: 8];
                end else begin
                    ev[i]         = (c > i);
                    ep[i*8 +: 8] = mem_m[k][(hd[k] + i) % 4096];
                end
            end
            run = 1'b1;
            for (int i = 0; i < 2; i++) begin
                df[i] = run & ev[i] & dq_rdy[i];
                run   = df[i];
            end
            chk($sformatf("rdy[%0d]", k), 32'(erdy[k]), 32'(er));
            chk($sformatf("dvld[%0d]", k), 32'(dvld[k]), 32'(ev));
            chk($sformatf("count[%0d]", k), 32'(cnt[k]), 32'(c));
            chk($sformatf("af[%0d]", k), 32'(af[k]), 32'(c >= D - 2));
            chk($sformatf("enq_ptr[%0d]", k), 32'(eptr[k]), 32'({ptrof(tl[k] + 1), ptrof(tl[k])}));
            chk($sformatf("deq_ptr[%0d]", k), 32'(dptr[k]), 32'({ptrof(hd[k] + 1), ptrof(hd[k])}));
            for (int i = 0; i < 2; i++)
                if (ev[i]) chk($sformatf("dpay[%0d] lane%0d", k, i), 32'(dpay[k][i*8 +: 8]), 32'(ep[i*8 +: 8]));
            ef_s[k] = ef;
            ne_s[k] = $countones(ef);
            nd_s[k] = $countones(df);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst || flush) begin
                hd[k] = 0;
                tl[k] = 0;
            end else begin
                for (int i = 0; i < 2; i++)
                    if (ef_s[k][i]) mem_m[k][(tl[k] + i) % 4096] = en_pay[i*8 +: 8];
                tl[k] += ne_s[k];
                hd[k] += nd_s[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] p, input logic [1:0] r, input logic f);
        en_vld = v;
        en_pay = p;
        dq_rdy = r;
        flush  = f;
    endtask

    task automatic step();
        #1;
        model_check();
    endtask

    initial begin
        mta = '{1'b1, 1'b0};
        byp = '{1'b0, 1'b1};
        hd  = '{0, 0};
        tl  = '{0, 0};
        ef_s = '{2'b00, 2'b00};
        ne_s = '{0, 0};
        nd_s = '{0, 0};
        rst = 1'b0;
        drive(2'b00, 16'h0, 2'b00, 1'b0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b1;

        drive(2'b00, 16'h0, 2'b00, 1'b0);
        step();
        chk("reset rdy_a", 32'(erdy[0]), 32'h3);
        chk("reset rdy_b", 32'(erdy[1]), 32'h3);
        chk("reset dvld_a", 32'(dvld[0]), 32'h0);
        chk("reset count_a", 32'(cnt[0]), 32'h0);
        chk("reset enq_ptr_a", 32'(eptr[0]), 32'h10);
        tick();

        for (int j = 0; j < 3; j++) begin
            drive(2'b11, {8'(8'h11 + 2 * j), 8'(8'h10 + 2 * j)}, 2'b00, 1'b0);
            step();
            tick();
            if (j == 0) chk("fill af at 2", 32'(af[0]), 32'h0);
            if (j == 1) chk("fill af at 4", 32'(af[0]), 32'h1);
        end
        chk("fill count_a", 32'(cnt[0]), 32'h6);
        chk("fill rdy_a", 32'(erdy[0]), 32'h0);
        chk("fill tail_a", 32'(eptr[0][3:0]), 32'h8);
        chk("fill count_b", 32'(cnt[1]), 32'h6);

        drive(2'b00, 16'h0, 2'b01, 1'b0);
        step();
        chk("wrap first data", 32'(dpay[0][7:0]), 32'h10);
        tick();
        for (int j = 0; j < 8; j++) begin
            drive(2'b01, {8'h00, 8'(8'h20 + j)}, 2'b01, 1'b0);
            step();
            if (j == 0) chk("wrap second data", 32'(dpay[1][7:0]), 32'h11);
            tick();
            if (j == 0) chk("wrap enq_ptr_b", 32'(eptr[1][3:0]), 32'h9);
        end
        chk("wrap head_b", 32'(dptr[1][3:0]), 32'hB);
        chk("wrap count_b", 32'(cnt[1]), 32'h5);
        for (int j = 0; j < 3; j++) begin
            drive(2'b00, 16'h0, 2'b11, 1'b0);
            step();
            tick();
        end
        chk("drain count_b", 32'(cnt[1]), 32'h0);

        drive(2'b11, 16'h3130, 2'b00, 1'b0);
        step();
        tick();
        drive(2'b00, 16'h0, 2'b10, 1'b0);
        step();
        tick();
        chk("gap deq count_a", 32'(cnt[0]), 32'h2);
        drive(2'b10, 16'h3332, 2'b00, 1'b0);
        step();
        tick();
        chk("gap enq count_a", 32'(cnt[0]), 32'h2);
        chk("gap enq count_b", 32'(cnt[1]), 32'h2);

        drive(2'b00, 16'h0, 2'b00, 1'b1);
        step();
        tick();
        drive(2'b11, 16'hB2A1, 2'b11, 1'b0);
        step();
        chk("bypass dvld_b", 32'(dvld[1]), 32'h3);
        chk("bypass dpay_b", 32'(dpay[1]), 32'hB2A1);
        chk("bypass dvld_a", 32'(dvld[0]), 32'h0);
        tick();
        chk("bypass count_b", 32'(cnt[1]), 32'h0);
        chk("bypass head_b", 32'(dptr[1][3:0]), 32'h2);
        chk("bypass tail_b", 32'(eptr[1][3:0]), 32'h2);
        chk("bypass count_a", 32'(cnt[0]), 32'h2);

        drive(2'b00, 16'h0, 2'b11, 1'b0);
        step();
        tick();
        drive(2'b11, 16'h4140, 2'b00, 1'b0);
        step();
        tick();
        drive(2'b11, 16'h4342, 2'b00, 1'b0);
        step();
        tick();
        drive(2'b11, 16'h5150, 2'b01, 1'b1);
        step();
        chk("flush cycle count_a", 32'(cnt[0]), 32'h4);
        chk("flush cycle count_b", 32'(cnt[1]), 32'h4);
        tick();
        drive(2'b00, 16'h0, 2'b00, 1'b0);
        step();
        chk("flush count_a", 32'(cnt[0]), 32'h0);
        chk("flush count_b", 32'(cnt[1]), 32'h0);
        chk("flush enq_ptr_a", 32'(eptr[0]), 32'h10);
        chk("flush deq_ptr_b", 32'(dptr[1]), 32'h10);
        chk("flush dvld_b", 32'(dvld[1]), 32'h0);
        tick();

        for (int j = 0; j < 1500; j++) begin
            rst = ($urandom_range(0, 59) != 0);
            drive(2'($urandom), 16'($urandom), 2'($urandom), ($urandom_range(0, 24) == 0));
            step();
            tick();
        end
        rst = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
